// File: rtl/button_pkg.sv
// Shared types and defaults for the button conditioner: per-channel FSM state
// encoding, default parameter values and a helper for sizing counters.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_t;

    localparam int DEF_N_CH             = 2;
    localparam int DEF_DB_CYCLES        = 4;
    localparam int DEF_PULSE_ON_RELEASE = 1;
    localparam int DEF_RPT_DELAY        = 0;
    localparam int DEF_RPT_PERIOD       = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Width is one bit wider than the largest count so saturation never aliases.
    function automatic int count_width(input int db, input int dly, input int per);
        return $clog2(max3(db, dly, per)) + 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, edge/auto-repeat
// pulse generation with a one-cycle registered strobe.
module btn_channel
    import button_pkg::*;
#(
    parameter int DB_CYCLES        = DEF_DB_CYCLES,
    parameter int PULSE_ON_RELEASE = DEF_PULSE_ON_RELEASE,
    parameter int RPT_DELAY        = DEF_RPT_DELAY,
    parameter int RPT_PERIOD       = DEF_RPT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    input  logic enable,
    output logic level,
    output logic pulse
);

    localparam int CW = count_width(DB_CYCLES, RPT_DELAY, RPT_PERIOD);
    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(RPT_PERIOD - 1);
    localparam bit RPT_EN = (RPT_DELAY > 0);
    localparam bit ON_RELEASE = (PULSE_ON_RELEASE != 0);

    logic          sync_meta;
    logic          sync_out;
    btn_state_t    state;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] rpt_cnt;
    logic          repeating;
    logic          level_d;

    logic [CW-1:0] db_inc;
    logic [CW-1:0] rpt_inc;
    logic          db_done;
    logic          rpt_fire;
    logic          edge_event;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= button;
            sync_out  <= sync_meta;
        end
    end

    // Counters saturate at all-ones; the current sample is the one that completes the count.
    always_comb begin
        db_inc     = (db_cnt == '1) ? db_cnt : db_cnt + 1'b1;
        rpt_inc    = (rpt_cnt == '1) ? rpt_cnt : rpt_cnt + 1'b1;
        db_done    = (db_cnt >= DB_LAST);
        rpt_fire   = 1'b0;
        if (RPT_EN && (state == HELD) && sync_out) begin
            rpt_fire = repeating ? (rpt_cnt >= PER_LAST) : (rpt_cnt >= DLY_LAST);
        end
        edge_event = ON_RELEASE ? (level_d & ~level) : (level & ~level_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            db_cnt    <= '0;
            rpt_cnt   <= '0;
            repeating <= 1'b0;
            level     <= 1'b0;
            level_d   <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            level_d <= level;
            // The !pulse term keeps two events from producing back-to-back strobes.
            pulse   <= enable && !pulse && (edge_event || rpt_fire);

            case (state)
                IDLE: begin
                    if (sync_out) begin
                        state  <= DB_PRESS;
                        db_cnt <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!sync_out) begin
                        state <= IDLE;
                    end else if (db_done) begin
                        state     <= HELD;
                        level     <= 1'b1;
                        rpt_cnt   <= '0;
                        repeating <= 1'b0;
                    end else begin
                        db_cnt <= db_inc;
                    end
                end
                HELD: begin
                    if (!sync_out) begin
                        state  <= DB_RELEASE;
                        db_cnt <= '0;
                    end else if (rpt_fire) begin
                        rpt_cnt   <= '0;
                        repeating <= 1'b1;
                    end else if (RPT_EN) begin
                        rpt_cnt <= rpt_inc;
                    end
                end
                DB_RELEASE: begin
                    if (sync_out) begin
                        state     <= HELD;
                        rpt_cnt   <= '0;
                        repeating <= 1'b0;
                    end else if (db_done) begin
                        state <= IDLE;
                        level <= 1'b0;
                    end else begin
                        db_cnt <= db_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: N_CH independent debounced channels, each
// producing a registered level and a one-cycle event pulse.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_CH             = DEF_N_CH,
    parameter int DB_CYCLES        = DEF_DB_CYCLES,
    parameter int PULSE_ON_RELEASE = DEF_PULSE_ON_RELEASE,
    parameter int RPT_DELAY        = DEF_RPT_DELAY,
    parameter int RPT_PERIOD       = DEF_RPT_PERIOD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] button,
    input  logic [N_CH-1:0] enable,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES       (DB_CYCLES),
            .PULSE_ON_RELEASE(PULSE_ON_RELEASE),
            .RPT_DELAY       (RPT_DELAY),
            .RPT_PERIOD      (RPT_PERIOD)
        ) u_channel (
            .clk   (clk),
            .reset (reset),
            .button(button[i]),
            .enable(enable[i]),
            .level (level[i]),
            .pulse (pulse[i])
        );
    end

endmodule
